minterm_sweep_checker: RTL and testbench
========================================

MINTERM_SWEEP_CHECKER -- requirements
Module: minterm_sweep_checker

Interface
REQ-001 Parameter: N_IN, default 4, number of truth-table inputs driven to the function under test; legal range 1..8.
REQ-002 Parameter: DWELL, default 10, clock cycles each input vector is held before its response is sampled; legal range >= 1.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request a new sweep; sampled only in IDLE or DONE.
REQ-006 Port: exp_mask  input  2**N_IN  expected output per vector; bit i is the expected F for input vector i.
REQ-007 Port: stop_on_fail  input  1  when 1, end the sweep at the first mismatch.
REQ-008 Port: dut_in  output  N_IN  vector driven to the function under test; MSB maps to the first literal (A).
REQ-009 Port: dut_f  input  1  response of the function under test.
REQ-010 Port: busy  output  1  high while a sweep is in progress.
REQ-011 Port: done  output  1  high from sweep completion until the next accepted start.
REQ-012 Port: pass  output  1  valid while done is high; 1 when err_count is 0.
REQ-013 Port: err_count  output  N_IN+1  number of mismatching vectors in the current or last sweep.
REQ-014 Port: first_fail  output  N_IN  vector index of the first mismatch.
REQ-015 Port: first_fail_valid  output  1  first_fail holds a recorded mismatch.

Function
REQ-016 States: IDLE, DRIVE, DONE; the design leaves reset in IDLE.
REQ-017 IDLE/DONE + start=1 at edge k: capture exp_mask and stop_on_fail into internal registers; set dut_in=0; clear err_count, first_fail, first_fail_valid, done and pass; clear the dwell counter; go to DRIVE.
REQ-018 start while in DRIVE is ignored; the port values of exp_mask and stop_on_fail do not affect a sweep in progress.
REQ-019 DRIVE: the dwell counter increments each cycle; the sample edge is the edge at which the counter equals DWELL-1.
REQ-020 Sample edge: compare dut_f against the captured exp_mask[dut_in]; on mismatch, increment err_count; if first_fail_valid=0, load first_fail=dut_in and set first_fail_valid=1.
REQ-021 Sample edge, with dut_in not all-ones and no stop condition: increment dut_in and clear the dwell counter.
REQ-022 Sample edge, with dut_in all-ones, or with a mismatch while captured stop_on_fail=1: go to DONE; dut_in holds its value.
REQ-023 Latency: vector i is sampled at edge k+(i+1)*DWELL; a full sweep asserts done after edge k+(2**N_IN)*DWELL.
REQ-024 busy=1 exactly in DRIVE; done=1 exactly in DONE; pass is registered as (err_count==0 including the final sample) on entry to DONE.
REQ-025 err_count never exceeds 2**N_IN and has no wrap; err_count and first_fail stay readable in DONE.
REQ-026 DONE + start=1 restarts immediately per REQ-017; start held high across consecutive sweeps starts back-to-back sweeps.

Reset
REQ-027 rst=1 forces, without waiting for clk: state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0, dwell counter=0, captured registers=0.
REQ-028 Reset during DRIVE abandons the sweep; after release, no activity occurs until a new start.

Verification
REQ-029 N_IN=4, DWELL=2, exp_mask=16'hA5C3, dut_f driven by a model of the same mask, start pulse -> done after 32 cycles, pass=1, err_count=0, first_fail_valid=0.
REQ-030 N_IN=4, DWELL=2, exp_mask=16'h0001, dut_f tied 0 -> err_count=1, first_fail=0, first_fail_valid=1, pass=0, dut_in=4'hF.
REQ-031 stop_on_fail=1, single mismatch at vector 5, DWELL=2 -> done after 12 cycles, dut_in=5, err_count=1, first_fail=5.
REQ-032 rst asserted while dut_in=7 in DRIVE -> all outputs reach reset values before the next clk edge; a later start runs a complete 16-vector sweep.
REQ-033 start pulsed during DRIVE -> no effect on the sweep; start held high through DONE -> the next sweep begins on the edge after done asserts, with done cleared.
REQ-034 Corner case N_IN=1, DWELL=1, exp_mask=2'b10, dut_f=dut_in -> done after 2 cycles, pass=1.

Source files
------------

// File: rtl/minterm_sweep_checker.sv
// Exhaustive truth-table sweep: drives every input vector to a combinational
// function, waits DWELL cycles, and checks its response against a mask.
module minterm_sweep_checker #(
    parameter int N_IN  = 4,
    parameter int DWELL = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp_mask,
    input  logic                 stop_on_fail,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_f,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_fail,
    output logic                 first_fail_valid
);

    localparam int NV = 2**N_IN;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NV-1:0]     mask_q, mask_d;
    logic              sof_q, sof_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              ffv_q, ffv_d;
    logic              pass_q, pass_d;
    logic              mism;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            sof_q   <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            sof_q   <= sof_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end

    assign mism = (dut_f != mask_q[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        sof_d   = sof_q;
        err_d   = err_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    mask_d  = exp_mask;
                    sof_d   = stop_on_fail;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q == LAST) begin
                    if (mism) begin
                        err_d = err_q + 1'b1;
                        if (!ffv_q) begin
                            ff_d  = vec_q;
                            ffv_d = 1'b1;
                        end
                    end
                    // pass must reflect the sample taken on this very edge
                    if ((&vec_q) || (mism && sof_q)) begin
                        state_d = DONE;
                        pass_d  = (err_q == '0) && !mism;
                    end else begin
                        vec_d = vec_q + 1'b1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dut_in           = vec_q;
    assign busy             = (state_q == DRIVE);
    assign done             = (state_q == DONE);
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Scoreboard bench: stimulus pushes predicted sweep outcomes, a monitor
// pops and compares them each time done rises.
module tb_minterm_sweep_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] exp_mask;
    logic        stop_on_fail;
    logic [3:0]  dut_in;
    logic        dut_f;
    logic        busy, done, pass;
    logic [4:0]  err_count;
    logic [3:0]  first_fail;
    logic        first_fail_valid;

    logic [15:0] act_mask;

    logic        start1;
    logic [1:0]  exp_mask1;
    logic [0:0]  dut_in1;
    logic        dut_f1;
    logic        busy1, done1, pass1;
    logic [1:0]  err1;
    logic [0:0]  ff1;
    logic        ffv1;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    logic done_seen = 1'b0;

    typedef struct {
        int err;
        int ff;
        bit ffv;
        bit pass;
        int last;
        int done_edge;
    } exp_t;

    exp_t sb[$];

    minterm_sweep_checker #(.N_IN(4), .DWELL(2)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .exp_mask(exp_mask), .stop_on_fail(stop_on_fail),
        .dut_in(dut_in), .dut_f(dut_f),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail(first_fail),
        .first_fail_valid(first_fail_valid)
    );

    minterm_sweep_checker #(.N_IN(1), .DWELL(1)) u_small (
        .clk(clk), .rst(rst), .start(start1),
        .exp_mask(exp_mask1), .stop_on_fail(1'b0),
        .dut_in(dut_in1), .dut_f(dut_f1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1),
        .first_fail_valid(ffv1)
    );

    // function under test: its real truth table may differ from the mask
    assign dut_f  = act_mask[dut_in];
    assign dut_f1 = dut_in1[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] m, input logic [15:0] a,
                                   input bit sof, input int k);
        exp_t r;
        r.err = 0;
        r.ff = 0;
        r.ffv = 0;
        r.last = 15;
        for (int i = 0; i < 16; i++) begin
            if (m[i] != a[i]) begin
                r.err++;
                if (!r.ffv) begin
                    r.ff = i;
                    r.ffv = 1;
                end
                if (sof) begin
                    r.last = i;
                    break;
                end
            end
        end
        r.pass = (r.err == 0);
        r.done_edge = k + (r.last + 1) * 2;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && done && !done_seen) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_edge", cyc, e.done_edge);
                chk("err_count", int'(err_count), e.err);
                chk("first_fail", int'(first_fail), e.ff);
                chk("ff_valid", int'(first_fail_valid), int'(e.ffv));
                chk("pass", int'(pass), int'(e.pass));
                chk("final_dut_in", int'(dut_in), e.last);
                chk("busy_in_done", int'(busy), 0);
            end
        end
        done_seen = done;
    end

    task automatic wait_empty(input int lim, input string nm);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk(nm, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_sweep(input logic [15:0] m, input logic [15:0] a,
                             input bit sof, input bit disturb);
        @(negedge clk);
        exp_mask = m;
        act_mask = a;
        stop_on_fail = sof;
        start = 1'b1;
        sb.push_back(model(m, a, sof, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            repeat (6) @(negedge clk);
            start = 1'b1;
            exp_mask = ~m;
            stop_on_fail = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_empty(200, "sweep_timeout");
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_dut_in"}, int'(dut_in), 0);
        chk({pfx, "_busy"}, int'(busy), 0);
        chk({pfx, "_done"}, int'(done), 0);
        chk({pfx, "_pass"}, int'(pass), 0);
        chk({pfx, "_err"}, int'(err_count), 0);
        chk({pfx, "_ff"}, int'(first_fail), 0);
        chk({pfx, "_ffv"}, int'(first_fail_valid), 0);
    endtask

    initial begin
        logic [15:0] m, a, flips;
        bit sof;
        exp_t e1, e2;
        int n;
        int k;

        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        exp_mask = '0;
        exp_mask1 = 2'b10;
        stop_on_fail = 1'b0;
        act_mask = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_sweep(16'hA5C3, 16'hA5C3, 1'b0, 1'b0);
        run_sweep(16'h0001, 16'h0000, 1'b0, 1'b0);
        run_sweep(16'h1234, 16'h1234 ^ 16'h0020, 1'b1, 1'b0);
        run_sweep(16'hFFFF, 16'h0000, 1'b0, 1'b0);
        run_sweep(16'h0F0F, 16'h0F0F ^ 16'h8000, 1'b1, 1'b0);
        run_sweep(16'h3C96, 16'h3C96 ^ 16'h0104, 1'b0, 1'b1);

        for (int i = 0; i < 14; i++) begin
            m = 16'($urandom);
            case ($urandom_range(0, 3))
                0: flips = 16'h0;
                1: flips = 16'(1 << $urandom_range(0, 15));
                default: flips = 16'($urandom & $urandom & $urandom);
            endcase
            sof = 1'($urandom_range(0, 1));
            run_sweep(m, m ^ flips, sof, 1'($urandom_range(0, 1)) & !sof);
        end

        // back-to-back sweeps with start held high
        @(negedge clk);
        m = 16'h5A5A;
        a = 16'h5A5A ^ 16'h0810;
        exp_mask = m;
        act_mask = a;
        stop_on_fail = 1'b0;
        start = 1'b1;
        e1 = model(m, a, 1'b0, cyc + 1);
        e2 = model(m, a, 1'b0, e1.done_edge + 1);
        sb.push_back(e1);
        sb.push_back(e2);
        n = 0;
        while (cyc < e1.done_edge + 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_restart_done", int'(done), 0);
        chk("b2b_restart_busy", int'(busy), 1);
        chk("b2b_restart_err", int'(err_count), 0);
        start = 1'b0;
        wait_empty(200, "b2b_timeout");

        // asynchronous reset in the middle of a sweep
        @(negedge clk);
        exp_mask = 16'hC3A5;
        act_mask = 16'h0000;
        start = 1'b1;
        sb.push_back(model(16'hC3A5, 16'h0000, 1'b0, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (dut_in != 4'd7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_vec7", int'(dut_in), 7);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_rst_busy", int'(busy), 0);
        chk("idle_after_rst_vec", int'(dut_in), 0);
        run_sweep(16'hC3A5, 16'hC3A5 ^ 16'h4002, 1'b0, 1'b0);

        // one-input, single-cycle-dwell instance
        @(negedge clk);
        start1 = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("small_latency", cyc - k, 2);
        chk("small_pass", int'(pass1), 1);
        chk("small_err", int'(err1), 0);
        chk("small_ffv", int'(ffv1), 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
